srwpl_serial_ctrl: RTL

Sequencer that drives the 2-bit mode select of the team's N-bit shift register with parallel load (00 hold, 01 load, 10 shift left, 11 shift right) to serialize parallel words. It accepts a word and a direction over a valid/ready handshake, loads the register, and steps it N times under serial-side backpressure. Each bit is presented MSB-first for left shifts or LSB-first for right shifts. It sits between a parallel producer and a bit-serial consumer; the register instance lives outside this block.

---
 rtl/srwpl_serial_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/srwpl_serial_ctrl.sv
// srwpl_serial_ctrl: drives the 2-bit mode select of an external N-bit shift
// register with parallel load (00 hold, 01 load, 10 shift left, 11 shift
// right) to serialize parallel words. A word and direction are accepted
// over a valid/ready handshake, loaded, then stepped N times under
// serial-side backpressure (MSB-first for left, LSB-first for right).
//
// Optional feature: define SRWPL_SERIAL_ABORT_EN to add an 'abort' input
// that cancels the word in progress and returns to IDLE without a done pulse.
module srwpl_serial_ctrl #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_data,
   input  logic         in_dir,
   output logic [1:0]   sel,
   output logic [N-1:0] sr_in,
   input  logic [N-1:0] sr_out,
   output logic         ser_valid,
   input  logic         ser_ready,
   output logic         ser_bit,
   output logic         busy,
   output logic         done
`ifdef SRWPL_SERIAL_ABORT_EN
   ,
   input  logic         abort
`endif
);

   localparam int CW = $clog2(N + 1);

   localparam logic [1:0] SEL_HOLD  = 2'b00;
   localparam logic [1:0] SEL_LOAD  = 2'b01;
   localparam logic [1:0] SEL_LEFT  = 2'b10;
   localparam logic [1:0] SEL_RIGHT = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_SHIFT,
      S_DONE
   } state_t;

   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q,   cnt_d;
   logic [N-1:0]   data_q,  data_d;
   logic           dir_q,   dir_d;
   logic           abort_w;

`ifdef SRWPL_SERIAL_ABORT_EN
   assign abort_w = abort;
`else
   assign abort_w = 1'b0;
`endif

   // Parallel load data is always the captured word.
   assign sr_in = data_q;

   // Serial bit taps the register end that leaves first for the direction.
   assign ser_bit = dir_q ? sr_out[0] : sr_out[N-1];

   // State, counter and captured word registers with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values regardless of statement order.
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         data_q  <= '0;
         dir_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         dir_q   <= dir_d;
      end
   end

   // Next-state logic and output decode from state and handshakes.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves one
      // unassigned, which would otherwise infer a latch.
      state_d   = state_q;
      cnt_d     = cnt_q;
      data_d    = data_q;
      dir_d     = dir_q;
      sel       = SEL_HOLD;
      in_ready  = 1'b0;
      ser_valid = 1'b0;
      done      = 1'b0;
      busy      = (state_q != S_IDLE);

      unique case (state_q)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               data_d  = in_data;
               dir_d   = in_dir;
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            sel     = SEL_LOAD;
            cnt_d   = '0;
            state_d = S_SHIFT;
         end
         S_SHIFT: begin
            ser_valid = 1'b1;
            if (ser_ready) begin
               sel = dir_q ? SEL_RIGHT : SEL_LEFT;
               if (cnt_q == CW'(N - 1)) begin
                  // Last bit: park the counter at zero rather than N.
                  cnt_d   = '0;
                  state_d = S_DONE;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Abort cancels any active word; the register is left holding.
      if (abort_w && (state_q != S_IDLE)) begin
         sel       = SEL_HOLD;
         ser_valid = 1'b0;
         done      = 1'b0;
         cnt_d     = '0;
         state_d   = S_IDLE;
      end

      // Reset masks all handshake and control outputs while asserted.
      if (rst) begin
         sel       = SEL_HOLD;
         in_ready  = 1'b0;
         ser_valid = 1'b0;
         done      = 1'b0;
         busy      = 1'b0;
      end
   end

endmodule
